instr_prefetch_queue: RTL and testbench

// - Fetch stage front end. Issues instruction-memory reads over a req/gnt/rvalid handshake.
// - Buffers returned {pc, instr} pairs in a small FIFO and hands them to the IF/ID register

---
 rtl/instr_prefetch_queue_pkg.sv | 20 ++
 rtl/instr_prefetch_queue_if.sv | 37 +++
 rtl/instr_prefetch_queue_fetch_fifo.sv | 59 +++++
 rtl/instr_prefetch_queue.sv | 111 +++++++++++
 tb/tb_instr_prefetch_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
//   PC_W / INS_W : fetch address and instruction widths
//   DEPTH        : prefetch FIFO entries (power of two, >= 2)
//   fetch_entry_t: one buffered {pc, instr} pair
//   fetch_state_e: fetch FSM states
package instr_prefetch_queue_pkg;
  localparam int PC_W    = 9;
  localparam int INS_W   = 32;
  localparam int DEPTH   = 4;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DISCARD} fetch_state_e;
endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle of the prefetch queue: redirect input, instruction-memory
// read port and the IF/ID output port.
//   master : the prefetch queue side
//   slave  : the environment side (memory, EX redirect, IF/ID consumer)
//
// Handshakes:
//   memory : mem_req_o/mem_addr_o are held stable until mem_gnt_i is seen
//            high in the same cycle; the single matching mem_rvalid_i /
//            mem_rdata_i arrives at least one cycle after the grant.
//   output : an entry transfers on every clock edge where out_valid_o and
//            out_ready_i are both high; while out_valid_o is high and
//            out_ready_i low the head fields do not change.
interface instr_prefetch_queue_if;
  import instr_prefetch_queue_pkg::*;

  logic             flush_i;
  logic [PC_W-1:0]  redirect_pc_i;
  logic             mem_req_o;
  logic [PC_W-1:0]  mem_addr_o;
  logic             mem_gnt_i;
  logic             mem_rvalid_i;
  logic [INS_W-1:0] mem_rdata_i;
  logic             out_valid_o;
  logic [PC_W-1:0]  out_pc_o;
  logic [INS_W-1:0] out_instr_o;
  logic             out_ready_i;

  modport master (
    input  flush_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, out_ready_i,
    output mem_req_o, mem_addr_o, out_valid_o, out_pc_o, out_instr_o
  );

  modport slave (
    output flush_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, out_ready_i,
    input  mem_req_o, mem_addr_o, out_valid_o, out_pc_o, out_instr_o
  );
endinterface

// File: rtl/instr_prefetch_queue_fetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : empties the FIFO (pointers and count to zero)
//   push, push_data : write one entry at the tail
//   pop          : drop the head entry
//   count_o      : occupancy
//   head_o       : entry at the head (registered storage)
// The caller never pushes into a full FIFO nor pops an empty one.
module instr_prefetch_queue_fetch_fifo
  import instr_prefetch_queue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch-stage front end. Issues one instruction-memory read at a time,
// buffers returned {pc, instr} pairs in a small FIFO and presents the head
// to the IF/ID register. A flush redirects fetch and discards any read in
// flight.
//   clk, reset : clock, synchronous active-high reset
//   bus        : instr_prefetch_queue_if.master (redirect, memory, output)
//   fetch_pc_o : next address to request (debug)
//   count_o    : FIFO occupancy (debug)
//   state_o    : fetch FSM state (debug)
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  instr_prefetch_queue_if.master bus,
  output logic [PC_W-1:0]        fetch_pc_o,
  output logic [CNT_W-1:0]       count_o,
  output fetch_state_e           state_o
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  // High for the first cycle after reset; keeps the request quiet then.
  logic             init_q, init_d;

  logic             mem_req;
  logic             push, pop, out_valid;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head, push_data;

  assign push_data = '{pc: req_pc_q, instr: bus.mem_rdata_i};

  instr_prefetch_queue_fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.flush_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count_o   (count),
    .head_o    (head)
  );

  assign out_valid = !reset && (count != '0);
  // Flush wins over a same-cycle pop; the FIFO is being cleared anyway.
  assign pop       = out_valid && bus.out_ready_i && !bus.flush_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    init_d     = 1'b0;
    mem_req    = 1'b0;
    push       = 1'b0;

    case (state_q)
      F_IDLE: begin
        // Registered count only: a pop this cycle does not free a slot yet,
        // which guarantees the returning data always finds room.
        mem_req = !reset && !init_q && !bus.flush_i && (count < CNT_W'(DEPTH));
        if (mem_req && bus.mem_gnt_i) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
          state_d    = F_WAIT;
        end
      end
      F_WAIT: begin
        if (bus.flush_i) begin
          // Data arriving in the flush cycle is simply dropped.
          state_d = bus.mem_rvalid_i ? F_IDLE : F_DISCARD;
        end else if (bus.mem_rvalid_i) begin
          push    = 1'b1;
          state_d = F_IDLE;
        end
      end
      F_DISCARD: begin
        // The stale read completes here; a further flush only moves fetch_pc.
        if (bus.mem_rvalid_i) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase

    if (bus.flush_i) fetch_pc_d = {bus.redirect_pc_i[PC_W-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      init_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      init_q     <= init_d;
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = reset ? '0 : fetch_pc_q;
  assign bus.out_valid_o = out_valid;
  assign bus.out_pc_o    = out_valid ? head.pc : '0;
  assign bus.out_instr_o = out_valid ? head.instr : '0;

  assign fetch_pc_o = reset ? '0 : fetch_pc_q;
  assign count_o    = reset ? '0 : count;
  assign state_o    = reset ? F_IDLE : state_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;
  import instr_prefetch_queue_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_prefetch_queue_if bus();
  logic [PC_W-1:0]  fetch_pc;
  logic [CNT_W-1:0] count;
  fetch_state_e     state;

  instr_prefetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .fetch_pc_o (fetch_pc),
    .count_o    (count),
    .state_o    (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- memory responder ----------------
  int   mem_lat  = 0;
  logic mem_kill = 1'b1;
  logic pend;
  logic [PC_W-1:0] paddr;
  int   pcnt;

  function automatic logic [INS_W-1:0] ins_of(logic [PC_W-1:0] a);
    return 32'hA500_0000 | INS_W'(a);
  endfunction

  initial begin
    pend = 1'b0;
    paddr = '0;
    pcnt = 0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (mem_kill) pend = 1'b0;
      else if (!reset && bus.mem_req_o && bus.mem_gnt_i) begin
        pend  = 1'b1;
        paddr = bus.mem_addr_o;
        pcnt  = mem_lat;
      end
      @(posedge clk);
      #1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      if (pend) begin
        if (pcnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = ins_of(paddr);
          pend = 1'b0;
        end else begin
          pcnt = pcnt - 1;
        end
      end
    end
  end

  // ---------------- scoreboard collection ----------------
  logic [PC_W-1:0]  got_pc_q[$];
  logic [INS_W-1:0] got_ins_q[$];
  logic [PC_W-1:0]  req_q[$];
  logic [PC_W-1:0]  exp_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.out_valid_o && bus.out_ready_i) begin
          got_pc_q.push_back(bus.out_pc_o);
          got_ins_q.push_back(bus.out_instr_o);
        end
        if (bus.mem_req_o && bus.mem_gnt_i) req_q.push_back(bus.mem_addr_o);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after reset release, at the first cycle requests may issue.
  task automatic apply_reset();
    reset = 1'b1;
    mem_kill = 1'b1;
    mem_lat = 0;
    bus.flush_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.mem_gnt_i = 1'b0;
    bus.out_ready_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mem_kill = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    mem_kill = 1'b1;
    bus.flush_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.mem_gnt_i = 1'b1;
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", bus.mem_req_o); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid_o); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_checks++; if (fetch_pc !== 9'h000) begin n_fail++; $display("FAIL rst_fetch_pc got=%h exp=0", fetch_pc); end
    n_checks++; if (state !== F_IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", state, F_IDLE); end
    reset = 1'b0;
    mem_kill = 1'b0;
    #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_req got=%b exp=0", bus.mem_req_o); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid got=%b exp=0", bus.out_valid_o); end
    tick();
    n_checks++; if (bus.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL first_req got=%b exp=1", bus.mem_req_o); end
    n_checks++; if (bus.mem_addr_o !== 9'h000) begin n_fail++; $display("FAIL first_addr got=%h exp=0", bus.mem_addr_o); end
  endtask

  task automatic test_stream();
    int b, rb;
    apply_reset();
    b = got_pc_q.size();
    rb = req_q.size();
    bus.mem_gnt_i = 1'b1;
    bus.out_ready_i = 1'b1;
    repeat (12) tick();
    bus.mem_gnt_i = 1'b0;
    repeat (4) tick();
    exp_q = '{9'h000, 9'h004, 9'h008, 9'h00C};
    n_checks++; if (req_q.size() - rb != 6) begin n_fail++; $display("FAIL stream_issue_rate got=%0d exp=6", req_q.size() - rb); end
    n_checks++;
    if (got_pc_q.size() - b < 4) begin
      n_fail++; $display("FAIL stream_out_count got=%0d exp>=4", got_pc_q.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (req_q[rb+i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_req_addr[%0d] got=%h exp=%h", i, req_q[rb+i], exp_q[i]); end
        n_checks++; if (got_pc_q[b+i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_out_pc[%0d] got=%h exp=%h", i, got_pc_q[b+i], exp_q[i]); end
        n_checks++; if (got_ins_q[b+i] !== ins_of(exp_q[i])) begin n_fail++; $display("FAIL stream_out_instr[%0d] got=%h exp=%h", i, got_ins_q[b+i], ins_of(exp_q[i])); end
      end
    end
  endtask

  task automatic test_full();
    int b, rb;
    apply_reset();
    b = got_pc_q.size();
    rb = req_q.size();
    bus.mem_gnt_i = 1'b1;
    bus.out_ready_i = 1'b0;
    repeat (12) tick();
    #1;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", count); end
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req got=%b exp=0", bus.mem_req_o); end
    n_checks++; if (req_q.size() - rb != 4) begin n_fail++; $display("FAIL full_issued got=%0d exp=4", req_q.size() - rb); end
    n_checks++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_valid got=%b exp=1", bus.out_valid_o); end
    repeat (3) begin
      n_checks++;
      if (bus.out_pc_o !== 9'h000 || bus.out_instr_o !== 32'hA500_0000) begin
        n_fail++; $display("FAIL full_head_stable got=%h/%h exp=000/a5000000", bus.out_pc_o, bus.out_instr_o);
      end
      tick();
    end
    bus.out_ready_i = 1'b1;
    #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_no_issue_on_pop got=%b exp=0", bus.mem_req_o); end
    tick();
    bus.out_ready_i = 1'b0;
    #1;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_count_after_pop got=%0d exp=3", count); end
    n_checks++; if (bus.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL full_req_after_pop got=%b exp=1", bus.mem_req_o); end
    n_checks++; if (bus.mem_addr_o !== 9'h010) begin n_fail++; $display("FAIL full_addr_after_pop got=%h exp=010", bus.mem_addr_o); end
    n_checks++; if (bus.out_pc_o !== 9'h004) begin n_fail++; $display("FAIL full_next_head got=%h exp=004", bus.out_pc_o); end
    n_checks++;
    if (got_pc_q.size() - b != 1) begin
      n_fail++; $display("FAIL full_pop_count got=%0d exp=1", got_pc_q.size() - b);
    end else begin
      n_checks++; if (got_pc_q[b] !== 9'h000) begin n_fail++; $display("FAIL full_popped_pc got=%h exp=000", got_pc_q[b]); end
    end
  endtask

  task automatic test_gnt_stall();
    int rb;
    apply_reset();
    rb = req_q.size();
    bus.mem_gnt_i = 1'b0;
    bus.out_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 9'h000 || fetch_pc !== 9'h000) begin
        n_fail++; $display("FAIL stall_hold[%0d] got req=%b addr=%h pc=%h exp req=1 addr=000 pc=000", i, bus.mem_req_o, bus.mem_addr_o, fetch_pc);
      end
      tick();
    end
    bus.mem_gnt_i = 1'b1;
    #1;
    n_checks++; if (fetch_pc !== 9'h000) begin n_fail++; $display("FAIL stall_pc_gnt_cycle got=%h exp=000", fetch_pc); end
    tick();
    bus.mem_gnt_i = 1'b0;
    #1;
    n_checks++; if (fetch_pc !== 9'h004) begin n_fail++; $display("FAIL stall_pc_after_gnt got=%h exp=004", fetch_pc); end
    n_checks++; if (state !== F_WAIT) begin n_fail++; $display("FAIL stall_state got=%0d exp=%0d", state, F_WAIT); end
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req_in_wait got=%b exp=0", bus.mem_req_o); end
    n_checks++; if (req_q.size() - rb != 1) begin n_fail++; $display("FAIL stall_grants got=%0d exp=1", req_q.size() - rb); end
  endtask

  task automatic test_flush();
    int b;
    apply_reset();
    b = got_pc_q.size();
    bus.mem_gnt_i = 1'b1;
    bus.out_ready_i = 1'b0;
    tick();
    mem_lat = 2;
    tick();
    #1;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=1", count); end
    n_checks++; if (bus.mem_addr_o !== 9'h004) begin n_fail++; $display("FAIL flush_pre_addr got=%h exp=004", bus.mem_addr_o); end
    tick();
    bus.flush_i = 1'b1;
    bus.redirect_pc_i = 9'h043;
    #1;
    n_checks++; if (state !== F_WAIT) begin n_fail++; $display("FAIL flush_in_wait got=%0d exp=%0d", state, F_WAIT); end
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_req_low got=%b exp=0", bus.mem_req_o); end
    tick();
    bus.flush_i = 1'b0;
    mem_lat = 0;
    #1;
    n_checks++; if (state !== F_DISCARD) begin n_fail++; $display("FAIL flush_discard got=%0d exp=%0d", state, F_DISCARD); end
    n_checks++; if (count !== 3'd0 || bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty got count=%0d valid=%b exp 0/0", count, bus.out_valid_o); end
    n_checks++; if (fetch_pc !== 9'h040) begin n_fail++; $display("FAIL flush_redirect_pc got=%h exp=040", fetch_pc); end
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_discard_req got=%b exp=0", bus.mem_req_o); end
    tick();
    n_checks++; if (state !== F_DISCARD || count !== 3'd0) begin n_fail++; $display("FAIL flush_stale_wait got state=%0d count=%0d exp %0d/0", state, count, F_DISCARD); end
    tick();
    n_checks++; if (state !== F_IDLE || count !== 3'd0) begin n_fail++; $display("FAIL flush_stale_dropped got state=%0d count=%0d exp %0d/0", state, count, F_IDLE); end
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 9'h040) begin n_fail++; $display("FAIL flush_new_req got req=%b addr=%h exp 1/040", bus.mem_req_o, bus.mem_addr_o); end
    tick();
    tick();
    n_checks++; if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 9'h040) begin n_fail++; $display("FAIL flush_first_out got valid=%b pc=%h exp 1/040", bus.out_valid_o, bus.out_pc_o); end
    n_checks++; if (bus.out_instr_o !== 32'hA500_0040) begin n_fail++; $display("FAIL flush_first_instr got=%h exp=a5000040", bus.out_instr_o); end
    tick();
    bus.flush_i = 1'b1;
    bus.redirect_pc_i = 9'h080;
    #1;
    n_checks++; if (state !== F_WAIT || bus.mem_rvalid_i !== 1'b1) begin n_fail++; $display("FAIL flush2_setup got state=%0d rvalid=%b exp %0d/1", state, bus.mem_rvalid_i, F_WAIT); end
    tick();
    bus.flush_i = 1'b0;
    #1;
    n_checks++; if (state !== F_IDLE) begin n_fail++; $display("FAIL flush2_state got=%0d exp=%0d", state, F_IDLE); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush2_count got=%0d exp=0", count); end
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 9'h080) begin n_fail++; $display("FAIL flush2_req got req=%b addr=%h exp 1/080", bus.mem_req_o, bus.mem_addr_o); end
    n_checks++; if (got_pc_q.size() != b) begin n_fail++; $display("FAIL flush_no_pops got=%0d exp=0", got_pc_q.size() - b); end
  endtask

  task automatic test_back_to_back();
    int b;
    apply_reset();
    b = got_pc_q.size();
    bus.mem_gnt_i = 1'b1;
    bus.out_ready_i = 1'b0;
    repeat (5) tick();
    #1;
    n_checks++; if (count !== 3'd2 || state !== F_WAIT) begin n_fail++; $display("FAIL b2b_setup got count=%0d state=%0d exp 2/%0d", count, state, F_WAIT); end
    bus.out_ready_i = 1'b1;
    tick();
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_push_pop_count got=%0d exp=2", count); end
    repeat (26) tick();
    bus.mem_gnt_i = 1'b0;
    repeat (6) tick();
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(PC_W'(4 * i));
    n_checks++;
    if (got_pc_q.size() - b < 10) begin
      n_fail++; $display("FAIL b2b_out_count got=%0d exp>=10", got_pc_q.size() - b);
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (got_pc_q[b+i] !== exp_q[i] || got_ins_q[b+i] !== ins_of(exp_q[i])) begin
          n_fail++; $display("FAIL b2b_order[%0d] got=%h/%h exp=%h/%h", i, got_pc_q[b+i], got_ins_q[b+i], exp_q[i], ins_of(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int b;
    apply_reset();
    b = got_pc_q.size();
    bus.mem_gnt_i = 1'b1;
    bus.out_ready_i = 1'b1;
    mem_lat = 2;
    tick();
    bus.mem_gnt_i = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (dut.state_q !== F_WAIT) begin n_fail++; $display("FAIL rstw_setup got=%0d exp=%0d", dut.state_q, F_WAIT); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (state !== F_IDLE) begin n_fail++; $display("FAIL rstw_state got=%0d exp=%0d", state, F_IDLE); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstw_count got=%0d exp=0", count); end
    n_checks++; if (fetch_pc !== 9'h000) begin n_fail++; $display("FAIL rstw_fetch_pc got=%h exp=000", fetch_pc); end
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rstw_req got=%b exp=0", bus.mem_req_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b0 || count !== 3'd0 || state !== F_IDLE) begin
        n_fail++; $display("FAIL rstw_stray[%0d] got valid=%b count=%0d state=%0d exp 0/0/%0d", i, bus.out_valid_o, count, state, F_IDLE);
      end
    end
    n_checks++; if (got_pc_q.size() != b) begin n_fail++; $display("FAIL rstw_no_output got=%0d exp=0", got_pc_q.size() - b); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_full();
    test_gnt_stall();
    test_flush();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
